// File: rtl/cheri_cap_pkg.sv
// Shared constants, FSM encoding and beat address helper for the capability memory sequencer.
package cheri_cap_pkg;

    localparam int unsigned CAP_W         = 129;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned CAP_BYTES     = 16;
    localparam int unsigned BEATS_PER_CAP = 4;
    localparam int unsigned BEAT_W        = $clog2(BEATS_PER_CAP);
    localparam int unsigned CAP_OFS_W     = $clog2(CAP_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    // Word-aligned byte address of one beat; cap beats stay inside their 16-byte granule.
    function automatic logic [31:0] beat_addr(input logic [31:2] addr_w,
                                              input logic        cap,
                                              input logic [1:0]  beat);
        beat_addr = cap ? {addr_w[31:4], beat, 2'b00} : {addr_w, 2'b00};
    endfunction

endpackage

// File: rtl/cap_tag_ram.sv
// Per-granule CHERI validity tag store: async clear, combinational read, synchronous write.
module cap_tag_ram #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic             din,
    output logic             rd_c
);

    logic [ENTRIES-1:0] tags;

    // Tag bits: cleared on reset, single-bit write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags <= '0;
        end else if (we) begin
            tags[idx] <= din;
        end
    end

    assign rd_c = tags[idx];

endmodule

// File: rtl/cap_mem_sequencer.sv
// Load/store sequencer between the MEM-stage request port and a 32-bit-word data memory.
// A capability access is split into four word beats, a word access is a single beat,
// and the validity tag lives in cap_tag_ram (one bit per 16-byte granule).
// Optional build macro CAP_ALIGN_CHECK_EN: misaligned requests return resp_err without
// touching memory; without it the offending low address bits are ignored.
module cap_mem_sequencer
    import cheri_cap_pkg::*;
#(
    parameter int unsigned TAG_ENTRIES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_cap,
    input  logic [31:0]       req_addr,
    input  logic [CAP_W-1:0]  req_wdata,
    output logic              resp_valid,
    output logic [CAP_W-1:0]  resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [CAP_W-1:0]  mem_wd,
    input  logic [CAP_W-1:0]  mem_rd
);

    localparam int unsigned IDX_W  = $clog2(TAG_ENTRIES);
    localparam int unsigned PAD_W  = CAP_W - WORD_W;
    localparam int unsigned DATA_W = CAP_W - 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_CAP - 1);

`ifdef CAP_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    seq_state_t          state;
    logic [BEAT_W-1:0]   beat;
    logic [31:2]         r_addr;
    logic [CAP_W-1:0]    r_wdata;
    logic                r_write;
    logic                r_cap;
    logic [DATA_W-1:0]   data;

    logic [BEAT_W-1:0]   nxt_beat_c;
    logic                last_c;
    logic                misalign_c;
    logic [DATA_W-1:0]   asm_c;
    logic [IDX_W-1:0]    gran_c;
    logic                tag_we_c;
    logic                tag_din_c;
    logic                tag_rd_c;
    logic                unused_mem_rd;

    assign unused_mem_rd = &{1'b0, mem_rd[CAP_W-1:WORD_W]};

    assign nxt_beat_c = beat + BEAT_W'(1);
    assign last_c     = ~r_cap | (beat == LAST_BEAT);
    assign misalign_c = ALIGN_CHECK & (req_cap ? (req_addr[3:0] != 4'd0)
                                               : (req_addr[1:0] != 2'd0));
    assign gran_c     = r_addr[CAP_OFS_W +: IDX_W];
    assign tag_we_c   = (state == ST_BEAT) & last_c & r_write;
    assign tag_din_c  = r_cap & r_wdata[CAP_W-1];

    // Load data with the word returned by the current beat merged in.
    always_comb begin
        asm_c = data;
        asm_c[{beat, 5'b00000} +: WORD_W] = mem_rd[WORD_W-1:0];
    end

    cap_tag_ram #(
        .ENTRIES (TAG_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_tag_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tag_we_c),
        .idx   (gran_c),
        .din   (tag_din_c),
        .rd_c  (tag_rd_c)
    );

    // Sequencer FSM: accept in IDLE, one memory beat per cycle, one-cycle response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_cap      <= 1'b0;
            data       <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr    <= req_addr[31:2];
                        r_wdata   <= req_wdata;
                        r_write   <= req_write;
                        r_cap     <= req_cap;
                        beat      <= '0;
                        req_ready <= 1'b0;
                        if (misalign_c) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ST_BEAT;
                            mem_read  <= ~req_write;
                            mem_write <= req_write;
                            mem_addr  <= beat_addr(req_addr[31:2], req_cap, 2'd0);
                            mem_wd    <= req_write ? {{PAD_W{1'b0}}, req_wdata[WORD_W-1:0]} : '0;
                        end
                    end
                end
                ST_BEAT: begin
                    if (!r_write) begin
                        data <= asm_c;
                    end
                    if (last_c) begin
                        state      <= ST_RESP;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        mem_addr   <= '0;
                        mem_wd     <= '0;
                        resp_valid <= 1'b1;
                        if (r_write) begin
                            resp_rdata <= '0;
                        end else if (r_cap) begin
                            resp_rdata <= {tag_rd_c, asm_c};
                        end else begin
                            resp_rdata <= {{PAD_W{1'b0}}, asm_c[WORD_W-1:0]};
                        end
                    end else begin
                        beat     <= nxt_beat_c;
                        mem_addr <= beat_addr(r_addr, r_cap, nxt_beat_c);
                        mem_wd   <= r_write ? {{PAD_W{1'b0}}, r_wdata[{nxt_beat_c, 5'b00000} +: WORD_W]}
                                            : '0;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cap_mem_sequencer.sv
// Directed scoreboard bench for cap_mem_sequencer with a 256-word memory model.
module tb_cap_mem_sequencer;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic         req_cap;
    logic [31:0]  req_addr;
    logic [128:0] req_wdata;
    logic         resp_valid;
    logic [128:0] resp_rdata;
    logic         resp_err;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [128:0] mem_wd;
    logic [128:0] mem_rd;

    typedef struct packed {logic [128:0] rdata; logic err;} resp_exp_t;
    typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_exp_t;

    resp_exp_t   exp_q[$];
    wr_exp_t     wr_q[$];
    logic [31:0] rd_log[$];
    resp_exp_t   me;
    wr_exp_t     mw;
    int          resp_cnt;
    int          errors;
    int          checks;
    logic [31:0] mem [0:255];

    localparam logic [31:0]  W0 = 32'h04030201;
    localparam logic [31:0]  W1 = 32'h08070605;
    localparam logic [31:0]  W2 = 32'h0C0B0A09;
    localparam logic [31:0]  W3 = 32'h0D0C0B0A;
    localparam logic [31:0]  A0 = 32'hA0A0A0A0;
    localparam logic [31:0]  A1 = 32'hA1A1A1A1;
    localparam logic [31:0]  A2 = 32'hA2A2A2A2;
    localparam logic [31:0]  A3 = 32'hA3A3A3A3;
    localparam logic [31:0]  DB = 32'hDEADBEEF;

    cap_mem_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_cap    (req_cap),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = {97'b0, mem[mem_addr[9:2]]};

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wd[31:0];
    end

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_resp(input logic [128:0] r, input logic e);
        exp_q.push_back({r, e});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_q.push_back({a, d});
    endtask

    // Scoreboard: compare responses and memory writes as the DUT produces them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 129'(resp_valid), 129'(0));
                end else begin
                    me = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, me.rdata);
                    chk("resp_err", 129'(resp_err), 129'(me.err));
                end
            end
            if (mem_write) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 129'(mem_write), 129'(0));
                end else begin
                    mw = wr_q.pop_front();
                    chk("wr_addr", 129'(mem_addr), 129'(mw.addr));
                    chk("wr_data", mem_wd, {97'b0, mw.data});
                end
            end
            if (mem_read) rd_log.push_back(mem_addr);
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 129'(req_ready), 129'(1));
        chk("rst_resp_valid", 129'(resp_valid), 129'(0));
        chk("rst_resp_rdata", resp_rdata, 129'(0));
        chk("rst_resp_err", 129'(resp_err), 129'(0));
        chk("rst_mem_read", 129'(mem_read), 129'(0));
        chk("rst_mem_write", 129'(mem_write), 129'(0));
        chk("rst_mem_addr", 129'(mem_addr), 129'(0));
        chk("rst_mem_wd", mem_wd, 129'(0));
    endtask

    // Drive one request, wait for acceptance, return the response cycle and ready in cycles 1/2.
    task automatic issue(input logic w, input logic c, input logic [31:0] a, input logic [128:0] d,
                         output int cyc, output logic rdy1, output logic rdy2);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_cap   = c;
        req_addr  = a;
        req_wdata = d;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc  = 0;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) rdy1 = req_ready;
            if (k == 2) rdy2 = req_ready;
            if (resp_valid) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          rc0;
        logic        rdy1;
        logic        rdy2;

        errors    = 0;
        checks    = 0;
        resp_cnt  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_cap   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;

        // Test 1: reset during beat 2 of a cap store.
        push_wr(32'h80, A0);
        push_wr(32'h84, A1);
        push_wr(32'h88, A2);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_cap   = 1'b1;
        req_addr  = 32'h80;
        req_wdata = {1'b1, A3, A2, A1, A0};
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        chk("t1_beats_seen", 129'(wr_q.size()), 129'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_beat1_kept", 129'(mem[8'h21]), 129'(A1));
        chk("t1_beat2_aborted", 129'(mem[8'h22]), 129'(0));
        push_resp({1'b0, 32'h0, 32'h0, A1, A0}, 1'b0);
        issue(1'b0, 1'b1, 32'h80, '0, cyc, rdy1, rdy2);
        chk("t1_load_lat", 129'(cyc), 129'(5));

        // Test 2: cap store then cap load of the same granule.
        push_wr(32'h40, W0);
        push_wr(32'h44, W1);
        push_wr(32'h48, W2);
        push_wr(32'h4C, W3);
        push_resp(129'(0), 1'b0);
        issue(1'b1, 1'b1, 32'h40, {1'b1, W3, W2, W1, W0}, cyc, rdy1, rdy2);
        chk("t2_store_lat", 129'(cyc), 129'(5));
        push_resp({1'b1, W3, W2, W1, W0}, 1'b0);
        issue(1'b0, 1'b1, 32'h40, '0, cyc, rdy1, rdy2);
        chk("t2_load_lat", 129'(cyc), 129'(5));

        // Test 3: word store invalidates the granule tag.
        push_wr(32'h44, DB);
        push_resp(129'(0), 1'b0);
        issue(1'b1, 1'b0, 32'h44, {97'b0, DB}, cyc, rdy1, rdy2);
        chk("t3_store_lat", 129'(cyc), 129'(2));
        push_resp({1'b0, W3, W2, DB, W0}, 1'b0);
        issue(1'b0, 1'b1, 32'h40, '0, cyc, rdy1, rdy2);
        chk("t3_load_lat", 129'(cyc), 129'(5));

        // Test 4: word load latency and ready timing.
        push_resp({97'b0, W2}, 1'b0);
        issue(1'b0, 1'b0, 32'h48, '0, cyc, rdy1, rdy2);
        chk("t4_lat", 129'(cyc), 129'(2));
        chk("t4_ready_c1", 129'(rdy1), 129'(0));
        chk("t4_ready_c2", 129'(rdy2), 129'(0));

        // Test 5: back-to-back word loads with req_valid held high.
        push_resp({97'b0, W0}, 1'b0);
        push_resp({97'b0, W3}, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_cap   = 1'b0;
        req_addr  = 32'h40;
        rc0 = resp_cnt;
        rd_log.delete();
        @(posedge clk);
        @(negedge clk);
        chk("t5_ready_c1", 129'(req_ready), 129'(0));
        req_addr = 32'h4C;
        @(negedge clk);
        chk("t5_ready_c2", 129'(req_ready), 129'(0));
        @(negedge clk);
        chk("t5_ready_c3", 129'(req_ready), 129'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_resp_pulses", 129'(resp_cnt - rc0), 129'(2));
        chk("t5_read_beats", 129'(rd_log.size()), 129'(2));
        if (rd_log.size() == 2) begin
            chk("t5_read_addr0", 129'(rd_log[0]), 129'(32'h40));
            chk("t5_read_addr1", 129'(rd_log[1]), 129'(32'h4C));
        end

        // Test 6: misaligned cap load.
        rd_log.delete();
`ifdef CAP_ALIGN_CHECK_EN
        push_resp(129'(0), 1'b1);
        issue(1'b0, 1'b1, 32'h44, '0, cyc, rdy1, rdy2);
        chk("t6_err_lat", 129'(cyc), 129'(1));
        chk("t6_no_reads", 129'(rd_log.size()), 129'(0));
`else
        push_resp({1'b0, W3, W2, DB, W0}, 1'b0);
        issue(1'b0, 1'b1, 32'h44, '0, cyc, rdy1, rdy2);
        chk("t6_lat", 129'(cyc), 129'(5));
        chk("t6_read_beats", 129'(rd_log.size()), 129'(4));
        if (rd_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t6_read_addr", 129'(rd_log[i]), 129'(32'h40 + 32'(4 * i)));
            end
        end
`endif

        repeat (3) @(negedge clk);
        chk("final_resp_queue_empty", 129'(exp_q.size()), 129'(0));
        chk("final_wr_queue_empty", 129'(wr_q.size()), 129'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
